// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: req/ack data-memory port between the MEM stage and data memory.
interface mem_wb_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
    modport slave (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with req/ack data access, stall generation and MEM/WB register (falling-edge).
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           ALUData,
    input  logic [31:0]           writeData,
    input  logic [4:0]            writeSrc,
    input  logic [31:0]           nextPC4,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            MemtoReg,
    input  logic                  RegWrite,
    mem_wb_stage_if.master        dm,
    output logic                  memStall,
    output logic [31:0]           wbData,
    output logic [4:0]            wbDst,
    output logic                  wbRegWrite,
    output logic                  alignErr,
    output logic                  busErr,
    output logic [31:0]           errAddr
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0] wb_dst_q, wb_dst_d;
    logic wb_rw_q, wb_rw_d;
    logic align_err_q, align_err_d, bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic stall, access, aligned, done;
    logic [31:0] sel_data;
    assign access  = MemRead | MemWrite;
    assign aligned = ALUData[1:0] == 2'b00;
    assign done    = (state_q == S_WAIT) & dm.dm_ack;
    // load data only ever comes from a completing access
    assign sel_data = MemtoReg == 2'b01 ? (done ? dm.dm_rdata : 32'd0) :
                      MemtoReg == 2'b10 ? nextPC4 : ALUData;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_data_d   = 32'd0;
        wb_dst_d    = 5'd0;
        wb_rw_d     = 1'b0;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        err_addr_d  = err_addr_q;
        stall       = 1'b0;
        if (state_q == S_IDLE) begin
            if (access && aligned) begin
                state_d = S_WAIT;
                cnt_d   = '0;
                req_d   = 1'b1;
                we_d    = MemWrite;
                addr_d  = ALUData;
                wdata_d = writeData;
                stall   = 1'b1;
            end else if (access) begin
                align_err_d = 1'b1;
                err_addr_d  = ALUData;
            end else begin
                wb_data_d = sel_data;
                wb_dst_d  = writeSrc;
                wb_rw_d   = RegWrite;
            end
        end else if (dm.dm_ack) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            wb_data_d = sel_data;
            wb_dst_d  = writeSrc;
            wb_rw_d   = RegWrite;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d    = S_IDLE;
            req_d      = 1'b0;
            bus_err_d  = 1'b1;
            err_addr_d = addr_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
            stall = 1'b1;
        end
    end
    always_ff @(negedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wb_data_q   <= 32'd0;
            wb_dst_q    <= 5'd0;
            wb_rw_q     <= 1'b0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_data_q   <= wb_data_d;
            wb_dst_q    <= wb_dst_d;
            wb_rw_q     <= wb_rw_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
        end
    end
    assign memStall    = RST ? 1'b0 : stall;
    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign wbData      = wb_data_q;
    assign wbDst       = wb_dst_q;
    assign wbRegWrite  = wb_rw_q;
    assign alignErr    = align_err_q;
    assign busErr      = bus_err_q;
    assign errAddr     = err_addr_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [31:0] ALUData, writeData, nextPC4;
    logic [4:0] writeSrc;
    logic MemWrite, MemRead, RegWrite;
    logic [1:0] MemtoReg;
    logic memStall, wbRegWrite, alignErr, busErr;
    logic [31:0] wbData, errAddr;
    logic [4:0] wbDst;
    int checks = 0;
    int failures = 0;
    int st, rq;
    mem_wb_stage_if dm_bus ();
    mem_wb_stage #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .ALUData(ALUData), .writeData(writeData), .writeSrc(writeSrc),
        .nextPC4(nextPC4), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .dm(dm_bus), .memStall(memStall), .wbData(wbData), .wbDst(wbDst),
        .wbRegWrite(wbRegWrite), .alignErr(alignErr), .busErr(busErr), .errAddr(errAddr)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                      input logic [31:0] pc4, input logic mw, input logic mr,
                      input logic [1:0] m2r, input logic rw);
        ALUData = alu; writeData = wd; writeSrc = dst; nextPC4 = pc4;
        MemWrite = mw; MemRead = mr; MemtoReg = m2r; RegWrite = rw;
    endtask
    task automatic nop();
        op(32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask
    task automatic step();
        @(posedge CLK);
    endtask
    initial begin
        dm_bus.dm_ack = 1'b0;
        dm_bus.dm_rdata = 32'd0;
        op(32'h40, 32'd0, 5'd1, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1);
        step(); step(); step(); #1;
        check("rst_stall", memStall, 0);
        check("rst_req", dm_bus.dm_req, 0);
        check("rst_wbdata", wbData, 0);
        check("rst_erraddr", errAddr, 0);
        // ALU op
        step(); RST = 1'b0;
        op(32'h1234, 32'd0, 5'd5, 32'd0, 1'b0, 1'b0, 2'b00, 1'b1); #1;
        check("alu_stall", memStall, 0);
        step();
        op(32'h55, 32'd0, 5'd31, 32'h100, 1'b0, 1'b0, 2'b10, 1'b1); #1;
        check("alu_wbdata", wbData, 32'h1234);
        check("alu_wbdst", wbDst, 5);
        check("alu_wbrw", wbRegWrite, 1);
        step();
        op(32'h99, 32'd0, 5'd4, 32'h200, 1'b0, 1'b0, 2'b11, 1'b1); #1;
        check("jal_wbdata", wbData, 32'h100);
        check("jal_wbdst", wbDst, 31);
        step(); #1;
        check("m2r11_wbdata", wbData, 32'h99);
        // load 0x40, ack three cycles after dm_req rises
        op(32'h40, 32'd0, 5'd7, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1); #1;
        check("ld_stall0", memStall, 1);
        step(); #1;
        check("ld_req", dm_bus.dm_req, 1);
        check("ld_addr", dm_bus.dm_addr, 32'h40);
        check("ld_we", dm_bus.dm_we, 0);
        check("ld_bubble", wbRegWrite, 0);
        check("ld_stall1", memStall, 1);
        step(); #1;
        check("ld_stall2", memStall, 1);
        step();
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hCAFEF00D; #1;
        check("ld_stall3", memStall, 0);
        step();
        dm_bus.dm_ack = 1'b0; nop(); #1;
        check("ld_wbdata", wbData, 32'hCAFEF00D);
        check("ld_wbdst", wbDst, 7);
        check("ld_wbrw", wbRegWrite, 1);
        check("ld_req_off", dm_bus.dm_req, 0);
        step(); #1;
        check("ld_wbrw_once", wbRegWrite, 0);
        // store 0x80
        op(32'h80, 32'hDEADBEEF, 5'd2, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        step(); #1;
        check("st_req", dm_bus.dm_req, 1);
        check("st_we", dm_bus.dm_we, 1);
        check("st_addr", dm_bus.dm_addr, 32'h80);
        check("st_wdata", dm_bus.dm_wdata, 32'hDEADBEEF);
        step(); #1;
        check("st_addr_hold", dm_bus.dm_addr, 32'h80);
        check("st_wdata_hold", dm_bus.dm_wdata, 32'hDEADBEEF);
        dm_bus.dm_ack = 1'b1;
        step();
        dm_bus.dm_ack = 1'b0; nop(); #1;
        check("st_req_off", dm_bus.dm_req, 0);
        check("st_wbrw", wbRegWrite, 0);
        // ack while idle is ignored
        dm_bus.dm_ack = 1'b1;
        step(); #1;
        check("idle_ack_req", dm_bus.dm_req, 0);
        check("idle_ack_stall", memStall, 0);
        dm_bus.dm_ack = 1'b0;
        // misaligned load
        op(32'h42, 32'd0, 5'd6, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1); #1;
        check("mis_stall", memStall, 0);
        step();
        nop(); #1;
        check("mis_alignerr", alignErr, 1);
        check("mis_erraddr", errAddr, 32'h42);
        check("mis_req", dm_bus.dm_req, 0);
        check("mis_wbrw", wbRegWrite, 0);
        step(); #1;
        check("mis_pulse", alignErr, 0);
        check("mis_erraddr_hold", errAddr, 32'h42);
        // timeout with no ack
        op(32'h100, 32'd0, 5'd3, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1); #1;
        check("to_stall0", memStall, 1);
        st = 0; rq = 0;
        for (int i = 0; i < 15; i++) begin
            step(); #1;
            if (memStall) st++;
            if (dm_bus.dm_req) rq++;
        end
        check("to_stall_cnt", st, 15);
        check("to_req_cnt", rq, 15);
        step(); #1;
        check("to_last_stall", memStall, 0);
        check("to_last_req", dm_bus.dm_req, 1);
        step();
        nop(); #1;
        check("to_buserr", busErr, 1);
        check("to_req_off", dm_bus.dm_req, 0);
        check("to_erraddr", errAddr, 32'h100);
        check("to_wbrw", wbRegWrite, 0);
        step(); #1;
        check("to_pulse", busErr, 0);
        // ack on the final timeout cycle completes normally
        op(32'h104, 32'd0, 5'd8, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 16; i++) step();
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hA5A5A5A5; #1;
        check("ack16_stall", memStall, 0);
        step();
        dm_bus.dm_ack = 1'b0; nop(); #1;
        check("ack16_buserr", busErr, 0);
        check("ack16_wbdata", wbData, 32'hA5A5A5A5);
        check("ack16_wbrw", wbRegWrite, 1);
        check("ack16_erraddr", errAddr, 32'h100);
        // reset during the second WAIT cycle
        op(32'h200, 32'd0, 5'd9, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1);
        step(); step();
        RST = 1'b1; #1;
        check("rst_mid_stall", memStall, 0);
        step();
        RST = 1'b0;
        op(32'd0, 32'd0, 5'd9, 32'd0, 1'b0, 1'b0, 2'b01, 1'b1);
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h77; #1;
        check("rst_mid_req", dm_bus.dm_req, 0);
        check("rst_mid_erraddr", errAddr, 0);
        check("rst_mid_wbdata", wbData, 0);
        check("rst_mid_addr", dm_bus.dm_addr, 0);
        step();
        dm_bus.dm_ack = 1'b0; #1;
        check("late_ack_wbdata", wbData, 0);
        check("late_ack_req", dm_bus.dm_req, 0);
        check("late_ack_stall", memStall, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
